// File: rtl/psum_accum_seq_pkg.sv
// Shared types and constants for the psum accumulation sequencer.
// The optional ReLU-bypass build is selected with PSUM_SEQ_RELU_BYPASS_EN.
package psum_accum_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    READ    = 3'd2,
    DRAIN   = 3'd3,
    RELU    = 3'd4,
    WRITE   = 3'd5,
    DONE_ST = 3'd6
  } state_t;

  // SRAM strobes are active-low
  localparam logic sram_act  = 1'b0;
  localparam logic sram_idle = 1'b1;

  // psum SRAM Q is valid this many cycles after a cycle with CEN low
  localparam int rd_latency = 1;

endpackage

// File: rtl/psum_accum_seq_if.sv
// SRAM and SFU side bus of the psum sequencer.
// The master is the sequencer; the slave is the SRAM/SFU environment.
interface psum_accum_seq_if #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11
);
  logic                     psum_cen;
  logic [addr_bw-1:0]       psum_addr;
  logic                     sfu_reset;
  logic                     sfu_mode;
  logic [psum_bw*col-1:0]   sfu_out;
  logic                     out_cen;
  logic                     out_wen;
  logic [addr_bw-1:0]       out_addr;
  logic [psum_bw*col-1:0]   out_d;

  modport master (
    output psum_cen, psum_addr, sfu_reset, sfu_mode,
    output out_cen, out_wen, out_addr, out_d,
    input  sfu_out
  );

  modport slave (
    input  psum_cen, psum_addr, sfu_reset, sfu_mode,
    input  out_cen, out_wen, out_addr, out_d,
    output sfu_out
  );
endinterface

// File: rtl/psum_accum_seq_addr_gen.sv
// Running psum/output address counters: base load, step-O read advance, per-row advance.
// Arithmetic wraps modulo 2^addr_bw; no multiplier is needed.
module psum_addr_gen #(
  parameter int addr_bw = 11,
  parameter int o_bw    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               row_next,
  input  logic [addr_bw-1:0] psum_base,
  input  logic [addr_bw-1:0] out_base,
  input  logic [o_bw-1:0]    num_o,
  output logic [addr_bw-1:0] rd_ptr,
  output logic [addr_bw-1:0] wr_ptr
);

  logic [addr_bw-1:0] row_base;
  logic [addr_bw-1:0] stride;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_base <= '0;
      stride   <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else if (load) begin
      row_base <= psum_base;
      stride   <= addr_bw'(num_o);
      rd_ptr   <= psum_base;
      wr_ptr   <= out_base;
    end else begin
      if (step)
        rd_ptr <= rd_ptr + stride;
      // rd_ptr restarts at the next row's k = 0 address
      if (row_next) begin
        row_base <= row_base + addr_bw'(1);
        rd_ptr   <= row_base + addr_bw'(1);
        wr_ptr   <= wr_ptr + addr_bw'(1);
      end
    end
  end

endmodule

// File: rtl/psum_accum_seq.sv
// Streams per-row partial sums from psum SRAM into the SFU, applies ReLU, writes output SRAM.
// Optional build macro PSUM_SEQ_RELU_BYPASS_EN adds relu_en to skip the ReLU step.
//
// state   | meaning
// IDLE    | waiting for start
// CLEAR   | SFU cleared for a new output row
// READ    | K psum reads, SFU accumulates the previous read
// DRAIN   | SFU accumulates the final read
// RELU    | SFU applies ReLU
// WRITE   | SFU result written to output SRAM
// DONE_ST | one-cycle done pulse
module psum_accum_seq
  import psum_accum_seq_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int kij_bw  = 4,
  parameter int o_bw    = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [kij_bw-1:0]  num_kij,
  input  logic [o_bw-1:0]    num_o,
  input  logic [addr_bw-1:0] psum_base,
  input  logic [addr_bw-1:0] out_base,
`ifdef PSUM_SEQ_RELU_BYPASS_EN
  input  logic               relu_en,
`endif
  output logic               busy,
  output logic               done,
  psum_accum_seq_if.master   bus
);

  state_t             state;
  logic [kij_bw-1:0]  k_num;
  logic [kij_bw-1:0]  k_left;
  logic [o_bw-1:0]    o_left;
  logic               ag_load;
  logic               ag_step;
  logic               ag_row;
  logic [addr_bw-1:0] rd_ptr;
  logic [addr_bw-1:0] wr_ptr;
`ifdef PSUM_SEQ_RELU_BYPASS_EN
  logic               relu_q;
`endif

  assign bus.out_d = bus.sfu_out;

  always_comb begin
    ag_load = (state == IDLE) && start;
    ag_step = (state == CLEAR) || ((state == READ) && (k_left != '0));
    ag_row  = (state == WRITE) && (o_left != '0);
  end

  psum_addr_gen #(
    .addr_bw (addr_bw),
    .o_bw    (o_bw)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (ag_load),
    .step      (ag_step),
    .row_next  (ag_row),
    .psum_base (psum_base),
    .out_base  (out_base),
    .num_o     (num_o),
    .rd_ptr    (rd_ptr),
    .wr_ptr    (wr_ptr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      k_num         <= '0;
      k_left        <= '0;
      o_left        <= '0;
      bus.psum_cen  <= sram_idle;
      bus.psum_addr <= '0;
      bus.sfu_reset <= 1'b0;
      bus.sfu_mode  <= 1'b0;
      bus.out_cen   <= sram_idle;
      bus.out_wen   <= sram_idle;
      bus.out_addr  <= '0;
`ifdef PSUM_SEQ_RELU_BYPASS_EN
      relu_q        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            k_num  <= num_kij;
            o_left <= num_o - o_bw'(1);
`ifdef PSUM_SEQ_RELU_BYPASS_EN
            relu_q <= relu_en;
`endif
            if ((num_kij == '0) || (num_o == '0)) begin
              state <= DONE_ST;
              done  <= 1'b1;
            end else begin
              state         <= CLEAR;
              busy          <= 1'b1;
              bus.sfu_reset <= 1'b1;
              bus.sfu_mode  <= 1'b0;
            end
          end
        end
        CLEAR: begin
          state         <= READ;
          bus.sfu_reset <= 1'b0;
          bus.sfu_mode  <= 1'b0;
          bus.psum_cen  <= sram_act;
          bus.psum_addr <= rd_ptr;
          k_left        <= k_num - kij_bw'(1);
        end
        READ: begin
          bus.sfu_mode <= 1'b1;
          if (k_left == '0) begin
            state        <= DRAIN;
            bus.psum_cen <= sram_idle;
          end else begin
            k_left        <= k_left - kij_bw'(1);
            bus.psum_addr <= rd_ptr;
          end
        end
        DRAIN: begin
          bus.sfu_mode <= 1'b0;
`ifdef PSUM_SEQ_RELU_BYPASS_EN
          if (!relu_q) begin
            state        <= WRITE;
            bus.out_cen  <= sram_act;
            bus.out_wen  <= sram_act;
            bus.out_addr <= wr_ptr;
          end else begin
            state <= RELU;
          end
`else
          state <= RELU;
`endif
        end
        RELU: begin
          state        <= WRITE;
          bus.sfu_mode <= 1'b0;
          bus.out_cen  <= sram_act;
          bus.out_wen  <= sram_act;
          bus.out_addr <= wr_ptr;
        end
        WRITE: begin
          bus.out_cen <= sram_idle;
          bus.out_wen <= sram_idle;
          if (o_left == '0) begin
            state <= DONE_ST;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            o_left        <= o_left - o_bw'(1);
            state         <= CLEAR;
            bus.sfu_reset <= 1'b1;
          end
        end
        DONE_ST: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accum_seq.sv
// Scoreboard bench for psum_accum_seq with psum SRAM and SFU behavioural models.
// Covers the PSUM_SEQ_RELU_BYPASS_EN build when that macro is defined.
module tb_psum_accum_seq;

  localparam int PB = 16;
  localparam int NC = 8;
  localparam int AB = 11;
  localparam int DW = PB * NC;

  typedef struct {
    logic [AB-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [3:0]    num_kij = '0;
  logic [6:0]    num_o = '0;
  logic [AB-1:0] psum_base = '0;
  logic [AB-1:0] out_base = '0;
  logic          relu_en = 1'b1;
  logic          busy;
  logic          done;

  int n_tests = 0;
  int n_fail = 0;

  logic [AB-1:0] rd_q[$];
  wr_t           wr_q[$];

  logic [DW-1:0] mem [2**AB];
  logic [DW-1:0] psum_q;
  logic [DW-1:0] sfu_acc;

  psum_accum_seq_if #(.psum_bw(PB), .col(NC), .addr_bw(AB)) bus ();

  psum_accum_seq #(
    .psum_bw(PB), .col(NC), .addr_bw(AB), .kij_bw(4), .o_bw(7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .num_kij   (num_kij),
    .num_o     (num_o),
    .psum_base (psum_base),
    .out_base  (out_base),
`ifdef PSUM_SEQ_RELU_BYPASS_EN
    .relu_en   (relu_en),
`endif
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  // psum SRAM (1-cycle read) and SFU: clear, accumulate, or per-lane ReLU
  always @(posedge clk) begin
    if (bus.psum_cen == 1'b0) psum_q <= mem[bus.psum_addr];
    if (bus.sfu_reset) sfu_acc <= '0;
    else
      for (int l = 0; l < NC; l++)
        if (bus.sfu_mode) sfu_acc[l*PB +: PB] <= sfu_acc[l*PB +: PB] + psum_q[l*PB +: PB];
        else if (sfu_acc[l*PB + PB - 1]) sfu_acc[l*PB +: PB] <= '0;
  end
  assign bus.sfu_out = sfu_acc;

  function automatic void check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void flag(string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: strobe seen with no expectation pending", name);
  endfunction

  // monitor: every psum read and output write is matched against the scoreboard
  always @(negedge clk) begin
    if (reset) begin
      if (bus.psum_cen == 1'b0) begin
        if (rd_q.size() == 0) flag("psum_read");
        else check("psum_addr", DW'(bus.psum_addr), DW'(rd_q.pop_front()));
      end
      if (bus.out_cen == 1'b0 || bus.out_wen == 1'b0) begin
        if (wr_q.size() == 0) flag("out_write");
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check("out_wen", DW'(bus.out_wen), DW'(0));
          check("out_addr", DW'(bus.out_addr), DW'(e.addr));
          check("out_d", bus.out_d, e.data);
        end
      end
    end
  end

  function automatic logic [DW-1:0] lanes(input int v[NC]);
    logic [DW-1:0] r;
    for (int l = 0; l < NC; l++) r[l*PB +: PB] = PB'(v[l]);
    return r;
  endfunction

  // expected row: per-lane sum of the row's K partial sums, 16-bit wrap, optional ReLU
  function automatic logic [DW-1:0] ref_row(int k, int o, int oi, logic [AB-1:0] pb, bit relu);
    logic [DW-1:0] r;
    for (int l = 0; l < NC; l++) begin
      int sum = 0;
      logic signed [PB-1:0] s;
      for (int kk = 0; kk < k; kk++) begin
        logic [DW-1:0] w;
        w = mem[AB'(int'(pb) + kk * o + oi)];
        sum += int'($signed(w[l*PB +: PB]));
      end
      s = PB'(sum);
      r[l*PB +: PB] = (relu && s < 0) ? '0 : s;
    end
    return r;
  endfunction

  task automatic run_job(input int k, input int o, input logic [AB-1:0] pb,
                         input logic [AB-1:0] ob, input bit relu, input int poke);
    int n;
    int exp_n;
    bit empty;
    empty = (k == 0) || (o == 0);
    for (int oi = 0; oi < o && !empty; oi++) begin
      wr_t e;
      for (int kk = 0; kk < k; kk++) rd_q.push_back(AB'(int'(pb) + kk * o + oi));
      e.addr = AB'(int'(ob) + oi);
      e.data = ref_row(k, o, oi, pb, relu);
      wr_q.push_back(e);
    end
    exp_n = empty ? 1 : 1 + o * (k + (relu ? 4 : 3));
    @(negedge clk);
    num_kij = 4'(k); num_o = 7'(o); psum_base = pb; out_base = ob; relu_en = relu;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk);
      n++;
      if (n == 1 && !empty) check("busy_after_start", DW'(busy), DW'(1));
      if (n == poke) begin
        start = 1'b1; num_kij = 4'd1; num_o = 7'd1; psum_base = ~pb; out_base = ~ob;
      end else if (n == poke + 1) start = 1'b0;
      if (done) break;
    end
    check("done_latency", DW'(n), DW'(exp_n));
    check("busy_at_done", DW'(busy), DW'(0));
    @(negedge clk);
    check("done_pulse_end", DW'(done), DW'(0));
    check("rd_q_drained", DW'(rd_q.size()), DW'(0));
    check("wr_q_drained", DW'(wr_q.size()), DW'(0));
    rd_q.delete();
    wr_q.delete();
  endtask

  initial begin
    int v[NC];
    int w[NC];
    int n;
    logic [AB-1:0] pb;

    for (int a = 0; a < 2**AB; a++) mem[a] = '0;
    repeat (3) @(negedge clk);
    check("rst_psum_cen", DW'(bus.psum_cen), DW'(1));
    check("rst_out_cen", DW'(bus.out_cen), DW'(1));
    check("rst_out_wen", DW'(bus.out_wen), DW'(1));
    check("rst_sfu_reset", DW'(bus.sfu_reset), DW'(0));
    check("rst_sfu_mode", DW'(bus.sfu_mode), DW'(0));
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_done", DW'(done), DW'(0));
    check("rst_psum_addr", DW'(bus.psum_addr), DW'(0));
    check("rst_out_addr", DW'(bus.out_addr), DW'(0));
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // K=1, O=1, all lanes 5
    for (int l = 0; l < NC; l++) v[l] = 5;
    mem[0] = lanes(v);
    run_job(1, 1, 11'h000, 11'h100, 1'b1, 0);

    // K=9, O=4, psum[k*4+o] = k+o
    for (int kk = 0; kk < 9; kk++)
      for (int oi = 0; oi < 4; oi++) begin
        for (int l = 0; l < NC; l++) v[l] = kk + oi;
        mem[kk * 4 + oi] = lanes(v);
      end
    run_job(9, 4, 11'h000, 11'h200, 1'b1, 0);

    // K=3, O=2: even lanes -7,2,1 / odd lanes 7,-2,1 in row 0, swapped in row 1
    v = '{-7, 7, -7, 7, -7, 7, -7, 7};
    w = '{7, -7, 7, -7, 7, -7, 7, -7};
    mem[11'h40] = lanes(v); mem[11'h41] = lanes(w);
    v = '{2, -2, 2, -2, 2, -2, 2, -2};
    w = '{-2, 2, -2, 2, -2, 2, -2, 2};
    mem[11'h42] = lanes(v); mem[11'h43] = lanes(w);
    for (int l = 0; l < NC; l++) v[l] = 1;
    mem[11'h44] = lanes(v); mem[11'h45] = lanes(v);
    run_job(3, 2, 11'h040, 11'h300, 1'b1, 0);

    // empty jobs: no SRAM access, done one cycle after start
    run_job(0, 5, 11'h010, 11'h020, 1'b1, 0);
    run_job(3, 0, 11'h010, 11'h020, 1'b1, 0);

    // restart attempt mid-job, with addresses wrapping past the top of SRAM
    for (int kk = 0; kk < 4 * 3; kk++) begin
      for (int l = 0; l < NC; l++) v[l] = int'($urandom_range(2000)) - 1000;
      mem[AB'(11'h7FA + kk)] = lanes(v);
    end
    run_job(4, 3, 11'h7FA, 11'h7FE, 1'b1, 3);

    // reset during READ aborts with no write
    @(negedge clk);
    num_kij = 4'd6; num_o = 7'd2; psum_base = 11'h100; out_base = 11'h180; relu_en = 1'b1;
    for (int kk = 0; kk < 6; kk++) rd_q.push_back(AB'(11'h100 + kk * 2));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (n < 50 && bus.psum_cen !== 1'b0) begin @(negedge clk); n++; end
    check("abort_reached_read", DW'(bus.psum_cen), DW'(0));
    #2 reset = 1'b0;
    #1;
    check("abort_psum_cen", DW'(bus.psum_cen), DW'(1));
    check("abort_out_cen", DW'(bus.out_cen), DW'(1));
    check("abort_busy", DW'(busy), DW'(0));
    @(posedge clk);
    #1;
    check("abort_psum_cen_edge", DW'(bus.psum_cen), DW'(1));
    check("abort_out_wen_edge", DW'(bus.out_wen), DW'(1));
    rd_q.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      int k = int'($urandom_range(15, 1));
      int o = int'($urandom_range(6, 1));
      pb = AB'($urandom);
      for (int a = 0; a < k * o; a++) begin
        for (int l = 0; l < NC; l++) v[l] = int'($urandom_range(2000)) - 1000;
        mem[AB'(int'(pb) + a)] = lanes(v);
      end
      run_job(k, o, pb, AB'($urandom), 1'b1, 0);
    end

`ifdef PSUM_SEQ_RELU_BYPASS_EN
    // ReLU skipped: negative accumulation written as-is, K+3 cycles per row
    for (int l = 0; l < NC; l++) v[l] = -3;
    mem[11'h500] = lanes(v);
    for (int l = 0; l < NC; l++) v[l] = -4;
    mem[11'h501] = lanes(v);
    run_job(2, 1, 11'h500, 11'h600, 1'b0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
